grf: RTL and testbench

GRF -- requirements
Module: grf

---
 rtl/grf.sv | 75 +++++++
 tb/tb_grf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/grf.sv
// General-purpose register file: 2**ADDR_W x DATA_W, two combinational read ports, one write port, register 0 hardwired to zero.
// Latency: reads are zero-cycle combinational; writes commit on the rising clk edge. GRF_BYPASS_EN adds same-cycle write-through forwarding.
// Backpressure: none; a write is accepted on every edge where we=1 and a3!=0, and reset wins over a simultaneous write.
module grf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [15:0]       wr_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;
  logic              wr_en;

  // A write only counts when it actually lands in storage; writes to register 0 are dropped.
  assign wr_en = we && !reset && (a3 != '0);

  // Next value of the committed-write counter; wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Storage and counter update; reset clears everything and takes priority over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[a3] <= wd;
      end
      cnt_q <= cnt_d;
    end
  end

  // Combinational read ports; address 0 is forced to zero even when forwarding.
  always_comb begin
    rd1 = regs_q[a1];
    rd2 = regs_q[a2];
`ifdef GRF_BYPASS_EN
    if (wr_en && (a1 == a3)) begin
      rd1 = wd;
    end
    if (wr_en && (a2 == a3)) begin
      rd2 = wd;
    end
`endif
    if (a1 == '0) begin
      rd1 = '0;
    end
    if (a2 == '0) begin
      rd2 = '0;
    end
  end

  assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed vector table, hand-written corner sequences, randomized traffic against a reference model, counter wrap.
// Latency: inputs change 1ns after each rising edge, combinational outputs sampled 1ns later, state checked 1ns after the edge.
// Backpressure: not applicable; every cycle the DUT accepts the driven request.
module tb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd;
  logic [31:0] rd1, rd2;
  logic [15:0] wr_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of register contents plus a write count.
  logic [31:0] mem [32];
  logic [15:0] model_cnt;

  grf #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .a1     (a1),
    .a2     (a2),
    .a3     (a3),
    .wd     (wd),
    .rd1    (rd1),
    .rd2    (rd2),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wen;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wdat;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // What a read port should show right now, given current inputs and the model state.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef GRF_BYPASS_EN
    if (we && !reset && a == a3) return wd;
`endif
    return mem[a];
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      model_cnt = 16'h0;
    end else if (we && a3 != 5'd0) begin
      mem[a3] = wd;
      model_cnt = model_cnt + 16'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; we = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    model_cnt = 16'h0;
  endtask

  initial begin
    logic [31:0] last_wd;

    reset = 1'b1; we = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd = '0;
    #1;
    tick();
    tick();
    reset = 1'b0;

    // Every address reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i);
      #1;
      check("post_reset_rd1", rd1, 32'h0);
      check("post_reset_rd2", rd2, 32'h0);
    end
    check("post_reset_cnt", {16'h0, wr_cnt}, 32'h0);

    // Directed vectors: one edge with the given request, then read back with we=0.
    vecs[0] = '{1'b1, 1'b1, 5'd5,  5'd0, 5'd5,  32'h00001234, 32'h0,        32'h0,        16'd0};
    vecs[1] = '{1'b0, 1'b1, 5'd8,  5'd5, 5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        16'd1};
    vecs[2] = '{1'b0, 1'b1, 5'd0,  5'd8, 5'd0,  32'hFFFFFFFF, 32'h0,        32'hDEADBEEF, 16'd1};
    vecs[3] = '{1'b0, 1'b1, 5'd2,  5'd8, 5'd2,  32'h00000007, 32'h7,        32'hDEADBEEF, 16'd2};
    vecs[4] = '{1'b0, 1'b1, 5'd2,  5'd3, 5'd3,  32'h00000009, 32'h7,        32'h9,        16'd3};
    vecs[5] = '{1'b0, 1'b0, 5'd3,  5'd3, 5'd4,  32'h00000055, 32'h9,        32'h9,        16'd3};
    vecs[6] = '{1'b0, 1'b1, 5'd3,  5'd4, 5'd3,  32'h0000000A, 32'hA,        32'h0,        16'd4};
    vecs[7] = '{1'b1, 1'b1, 5'd3,  5'd8, 5'd3,  32'h00000077, 32'h0,        32'h0,        16'd0};
    vecs[8] = '{1'b0, 1'b1, 5'd31, 5'd8, 5'd31, 32'h00003008, 32'h00003008, 32'h0,        16'd1};

    for (int v = 0; v < 9; v++) begin
      reset = vecs[v].rst; we = vecs[v].wen; a3 = vecs[v].wa; wd = vecs[v].wdat;
      a1 = 5'd0; a2 = 5'd0;
      tick();
      reset = 1'b0; we = 1'b0;
      a1 = vecs[v].ra1; a2 = vecs[v].ra2;
      #1;
      check($sformatf("vec%0d_rd1", v), rd1, vecs[v].e1);
      check($sformatf("vec%0d_rd2", v), rd2, vecs[v].e2);
      check($sformatf("vec%0d_cnt", v), {16'h0, wr_cnt}, {16'h0, vecs[v].ecnt});
    end

    // Same-cycle visibility of a pending write depends on forwarding.
    do_reset();
    we = 1'b1; a3 = 5'd31; wd = 32'h00003008; a2 = 5'd31; a1 = 5'd0;
    #1;
`ifdef GRF_BYPASS_EN
    check("bypass_pre_edge_rd2", rd2, 32'h00003008);
`else
    check("bypass_pre_edge_rd2", rd2, 32'h0);
`endif
    check("bypass_rd1_zero_reg", rd1, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("bypass_post_edge_rd2", rd2, 32'h00003008);

    // Back-to-back writes to one address: the latest data wins each edge.
    we = 1'b1; a3 = 5'd9; a1 = 5'd9; a2 = 5'd9; wd = 32'h11111111;
    tick();
    we = 1'b0;
    #1;
    check("b2b_first_rd1", rd1, 32'h11111111);
    we = 1'b1; wd = 32'h22222222;
    tick();
    wd = 32'h33333333;
    tick();
    we = 1'b0;
    #1;
    check("b2b_last_rd1", rd1, 32'h33333333);
    check("b2b_last_rd2", rd2, 32'h33333333);
    check("b2b_cnt", {16'h0, wr_cnt}, 32'd4);

    // Reset in the middle of a write stream leaves no trace of the dropped write.
    do_reset();
    we = 1'b1; a3 = 5'd6; wd = 32'h00000066;
    tick();
    reset = 1'b1; wd = 32'h00000099;
    tick();
    reset = 1'b0; a3 = 5'd7; wd = 32'h00000077;
    tick();
    we = 1'b0; a1 = 5'd6; a2 = 5'd7;
    #1;
    check("midreset_reg6", rd1, 32'h0);
    check("midreset_reg7", rd2, 32'h00000077);
    check("midreset_cnt", {16'h0, wr_cnt}, 32'd1);

    // Randomized traffic against the model; addresses biased towards a small set for collisions.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      we    = ($urandom_range(0, 3) != 0);
      a1    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a2    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a3    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) a2 = a1;
      wd    = $urandom;
      #1;
      check("rand_rd1", rd1, model_read(a1));
      check("rand_rd2", rd2, model_read(a2));
      check("rand_cnt", {16'h0, wr_cnt}, {16'h0, model_cnt});
      @(posedge clk);
      model_edge();
      #1;
    end

    // Counter wrap: 65536 committed writes bring the count back to zero.
    do_reset();
    last_wd = 32'h0;
    for (int i = 0; i < 65536; i++) begin
      we = 1'b1; a3 = 5'd1; wd = $urandom; last_wd = wd;
      tick();
      if (i == 65534) check("wrap_cnt_ffff", {16'h0, wr_cnt}, 32'h0000FFFF);
    end
    we = 1'b0; a1 = 5'd1; a2 = 5'd0;
    #1;
    check("wrap_cnt_zero", {16'h0, wr_cnt}, 32'h0);
    check("wrap_reg1_last", rd1, last_wd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
